// File: rtl/gcore_pkg.sv
// Shared widths, state encoding and address helpers for the gcore
// instruction prefetch slice.
package gcore_pkg;

  localparam int unsigned INST_W     = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WORD_BYTES = 4;

  // Clears the byte-offset bits of a byte address to give a word address.
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_FETCH,
    PF_DRAIN
  } pf_state_e;

  // Next sequential word address; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] next_word(input logic [ADDR_W-1:0] addr);
    return addr + ADDR_W'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/gcore_inst_fifo.sv
// Synchronous instruction-word FIFO with push/pop/flush.
// Flush wins over a simultaneous push or pop; head word reads as 0 when empty.
module gcore_inst_fifo
  import gcore_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = AW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [INST_W-1:0] data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [INST_W-1:0] data_o,
  output logic [CW-1:0]     count_o,
  output logic              empty_o,
  output logic              full_o
);

  logic [INST_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push;
  logic              do_pop;

  // Pointer and occupancy update; flush resets everything to empty.
  always_comb begin
    do_push  = push_i && !flush_i;
    do_pop   = pop_i && !flush_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Word storage; no reset needed since reads are gated by occupancy.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/gcore_inst_prefetch.sv
// Instruction prefetch buffer in front of the graphics core.
// Fetches sequential words into a FIFO, serves the core's address/valid
// interface and refetches from a new address on any non-sequential jump.
// Optional redirect counter: define GCORE_PREFETCH_STATS_EN.
module gcore_inst_prefetch
  import gcore_pkg::*;
#(
  parameter int unsigned       DEPTH      = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [INST_W-1:0] inst_in,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [INST_W-1:0] mem_data,
  input  logic              mem_ready,
  output logic [15:0]       flush_cnt
);

  localparam int unsigned CW = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

  pf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] head_addr_q, head_addr_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic [ADDR_W-1:0] req_word;
  logic [ADDR_W-1:0] seq_addr;
  logic              is_seq;
  logic              redirect;
  logic              push;
  logic              credit;
  logic              outstanding;

  logic [INST_W-1:0] fifo_data;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

  gcore_inst_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .data_i  (mem_data),
    .pop_i   (is_seq),
    .flush_i (redirect),
    .data_o  (fifo_data),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Classify the core's address against the FIFO head. With an empty FIFO
  // the core may only wait on fetch_addr; anything else is a jump.
  always_comb begin
    req_word = inst_addr & WORD_MASK;
    seq_addr = next_word(head_addr_q);
    if (fifo_empty) begin
      is_seq   = 1'b0;
      redirect = (req_word != fetch_addr_q);
    end else begin
      is_seq   = (req_word == seq_addr);
      redirect = (req_word != head_addr_q) && !is_seq;
    end
  end

  // Head address follows pops and is re-seeded by a redirect.
  always_comb begin
    head_addr_d = head_addr_q;
    if (redirect)    head_addr_d = req_word;
    else if (is_seq) head_addr_d = seq_addr;
  end

  assign outstanding = (state_q != PF_IDLE);
  assign credit      = (fifo_count + CW'(outstanding)) < CW'(DEPTH);

  // Fetch FSM: issue from IDLE, complete in FETCH, swallow a stale word in DRAIN.
  // A redirect always overrides fetch_addr, whatever the state.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    mem_addr_d   = mem_addr_q;
    push         = 1'b0;
    case (state_q)
      PF_IDLE: begin
        if (credit && !redirect) begin
          state_d    = PF_FETCH;
          mem_addr_d = fetch_addr_q;
        end
      end
      PF_FETCH: begin
        if (mem_ready) begin
          state_d = PF_IDLE;
          if (!redirect) begin
            push         = 1'b1;
            fetch_addr_d = next_word(fetch_addr_q);
          end
        end else if (redirect) begin
          state_d = PF_DRAIN;
        end
      end
      PF_DRAIN: begin
        if (mem_ready) state_d = PF_IDLE;
      end
      default: state_d = PF_IDLE;
    endcase
    if (redirect) fetch_addr_d = req_word;
  end

  // State and address registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= PF_IDLE;
      head_addr_q  <= RESET_ADDR;
      fetch_addr_q <= RESET_ADDR;
      mem_addr_q   <= RESET_ADDR;
    end else begin
      state_q      <= state_d;
      head_addr_q  <= head_addr_d;
      fetch_addr_q <= fetch_addr_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign mem_rd     = outstanding;
  assign mem_addr   = mem_addr_q;
  assign inst_in    = fifo_data;
  assign inst_valid = !fifo_empty && (req_word == head_addr_q);

  // Credit gating must keep a completing fetch from landing in a full FIFO.
  assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full));

`ifdef GCORE_PREFETCH_STATS_EN
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating count of redirects.
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // Redirect counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flush_cnt_q <= '0;
    else      flush_cnt_q <= flush_cnt_d;
  end

  assign flush_cnt = flush_cnt_q;
`else
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_gcore_inst_prefetch.sv
// Bench for gcore_inst_prefetch: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, and a memory responder
// with programmable wait states.
module tb_gcore_inst_prefetch;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] RA    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_addr = 32'h0;
  logic [31:0] inst_in;
  logic        inst_valid;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_data = 32'h0;
  logic        mem_ready = 1'b0;
  logic [15:0] flush_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  gcore_inst_prefetch #(
    .DEPTH      (DEPTH),
    .RESET_ADDR (RA)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_addr  (inst_addr),
    .inst_in    (inst_in),
    .inst_valid (inst_valid),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wordf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: completes a request after mem_wait stalled cycles and
  // logs every completed address (including ones the DUT discards).
  int          mem_wait = 0;
  logic [31:0] logq[$];

  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_ready = 1'b0;
        wcnt      = 0;
      end else begin
        if (mem_ready) wcnt = 0;
        mem_ready = 1'b0;
        mem_data  = 32'hDEAD_BEEF;
        if (mem_rd === 1'b1) begin
          if (wcnt >= mem_wait) begin
            mem_ready = 1'b1;
            mem_data  = wordf(mem_addr);
            logq.push_back(mem_addr);
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  function automatic logic [31:0] q_at(input int i);
    if (i < logq.size()) return logq[i];
    return 32'hxxxx_xxxx;
  endfunction

  // Reference model: FIFO as a queue of fetched word addresses, plus the
  // fetch pointer and a single outstanding request that may be abandoned.
  logic [31:0] mq[$];
  logic [31:0] m_head, m_fetch, m_req;
  bit          m_out, m_disc;
  int          m_flush;

  always @(negedge clk) begin
    logic [31:0] ia;
    logic [31:0] e_inst;
    logic [15:0] e_flush;
    bit          e_valid, seq, redir, empty;
    #2;
    if (!rst) begin
      mq.delete();
      m_head  = RA;
      m_fetch = RA;
      m_req   = RA;
      m_out   = 1'b0;
      m_disc  = 1'b0;
      m_flush = 0;
    end
    ia      = {inst_addr[31:2], 2'b00};
    empty   = (mq.size() == 0);
    e_valid = !empty && (ia == m_head);
    e_inst  = empty ? 32'h0 : wordf(mq[0]);
`ifdef GCORE_PREFETCH_STATS_EN
    e_flush = 16'(m_flush);
`else
    e_flush = 16'h0;
`endif
    chk("inst_valid", {31'h0, inst_valid}, {31'h0, e_valid});
    chk("inst_in", inst_in, e_inst);
    chk("mem_rd", {31'h0, mem_rd}, {31'h0, m_out});
    chk("mem_addr", mem_addr, m_req);
    chk("flush_cnt", {16'h0, flush_cnt}, {16'h0, e_flush});
    if (rst) begin
      seq   = !empty && (ia == m_head + 32'd4);
      redir = empty ? (ia != m_fetch) : ((ia != m_head) && !seq);
      if (m_out) begin
        if (mem_ready) begin
          if (!m_disc && !redir) begin
            mq.push_back(m_fetch);
            m_fetch = m_fetch + 32'd4;
          end
          m_out  = 1'b0;
          m_disc = 1'b0;
        end else if (redir) begin
          m_disc = 1'b1;
        end
      end else if (!redir && (mq.size() < DEPTH)) begin
        m_out = 1'b1;
        m_req = m_fetch;
      end
      if (seq) begin
        void'(mq.pop_front());
        m_head = m_head + 32'd4;
      end
      if (redir) begin
        mq.delete();
        m_head  = ia;
        m_fetch = ia;
        if (m_flush < 65535) m_flush++;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_valid;
    int got;
    int c;
    first_valid = -1;

    // Reset, then wait on address 0 and let the FIFO fill.
    #1 rst = 1'b0;
    cycles(3);
    rst = 1'b1;
    for (int k = 0; k < 30; k++) begin
      #3;
      if (first_valid < 0 && inst_valid === 1'b1) first_valid = k;
      @(negedge clk);
    end
    #3;
    chk("first_valid_cycle", 32'(first_valid), 32'd2);
    chk("reset_fetch0", q_at(0), 32'h0000_0000);
    chk("reset_fetch1", q_at(1), 32'h0000_0004);
    chk("reset_fetch2", q_at(2), 32'h0000_0008);
    chk("reset_word0", inst_in, 32'h1234_5678);

    // Stall on 0x10: exactly DEPTH words, then idle; one step frees one slot.
    @(negedge clk);
    logq.delete();
    inst_addr = 32'h10;
    cycles(30);
    #3;
    chk("stall_count", 32'(logq.size()), 32'd8);
    chk("stall_first", q_at(0), 32'h10);
    chk("stall_last", q_at(7), 32'h2C);
    chk("stall_idle", {31'h0, mem_rd}, 32'h0);
    @(negedge clk);
    inst_addr = 32'h14;
    cycles(8);
    #3;
    chk("step_count", 32'(logq.size()), 32'd9);
    chk("step_fetch", q_at(8), 32'h30);

    // Jump from a FIFO holding 0x20..0x3C to 0x100.
    @(negedge clk);
    inst_addr = 32'h20;
    cycles(30);
    logq.delete();
    inst_addr = 32'h100;
    #3;
    chk("jump_valid_drop", {31'h0, inst_valid}, 32'h0);
    cycles(30);
    #3;
    chk("jump_fetch", q_at(0), 32'h100);

    // Jump while a slow fetch of 0x40 is outstanding.
    @(negedge clk);
    mem_wait  = 5;
    logq.delete();
    inst_addr = 32'h40;
    got = 0;
    c = 0;
    while (!got && c < 10) begin
      @(negedge clk);
      #3;
      if (mem_rd === 1'b1) got = 1;
      c++;
    end
    chk("outst_req_seen", 32'(got), 32'd1);
    chk("outst_req_addr", mem_addr, 32'h40);
    cycles(2);
    inst_addr = 32'h200;
    got = 0;
    c = 0;
    while (!got && c < 80) begin
      @(negedge clk);
      #3;
      if (inst_valid === 1'b1) got = 1;
      c++;
    end
    chk("outst_valid_seen", 32'(got), 32'd1);
    chk("outst_discarded", q_at(0), 32'h40);
    chk("outst_refetch", q_at(1), 32'h200);
    chk("outst_word", inst_in, 32'h1034_5678);

    // Redirect in the very cycle the memory completes.
    @(negedge clk);
    mem_wait = 0;
    cycles(40);
    logq.delete();
    inst_addr = 32'h300;
    @(negedge clk);
    @(negedge clk);
    inst_addr = 32'h400;
    #3;
    chk("coin_rd", {31'h0, mem_rd}, 32'h1);
    chk("coin_addr", mem_addr, 32'h300);
    @(negedge clk);
    #3;
    chk("coin_no_stale", {31'h0, inst_valid}, 32'h0);
    cycles(30);
    #3;
    chk("coin_fetch0", q_at(0), 32'h300);
    chk("coin_fetch1", q_at(1), 32'h400);

    // Address wrap at the top of the 32-bit space, then walk across it.
    @(negedge clk);
    logq.delete();
    inst_addr = 32'hFFFF_FFF8;
    cycles(20);
    #3;
    chk("wrap_fetch0", q_at(0), 32'hFFFF_FFF8);
    chk("wrap_fetch1", q_at(1), 32'hFFFF_FFFC);
    chk("wrap_fetch2", q_at(2), 32'h0000_0000);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      inst_addr = inst_addr + 32'd4;
      @(negedge clk);
    end

    // Byte-offset bits ignored; sequential walk with pop and push overlapping.
    @(negedge clk);
    inst_addr = 32'h503;
    cycles(6);
    #3;
    chk("misalign_valid", {31'h0, inst_valid}, 32'h1);
    chk("misalign_word", inst_in, 32'h1734_5678);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      inst_addr = inst_addr + 32'd4;
      @(negedge clk);
    end
    cycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gcore_inst_prefetch.md
Name: gcore_inst_prefetch

Overview:
- Instruction prefetch buffer directly upstream of the graphics core.
- Fetches sequential 32-bit instruction words from the instruction memory port into a small FIFO.
- Serves the core's inst_addr/inst_in/inst_valid interface.
- Detects non-sequential core addresses (jumps), flushes the FIFO and refetches from the new address.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- RESET_ADDR, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- inst_addr  in  32  core's requested instruction byte address; bits [1:0] ignored
- inst_in  out  32  instruction word at FIFO head
- inst_valid  out  1  inst_in is the word for inst_addr
- mem_addr  out  32  word-aligned fetch address to instruction memory
- mem_rd  out  1  fetch request; held with mem_addr stable until mem_ready
- mem_data  in  32  returned instruction word, valid when mem_ready=1
- mem_ready  in  1  one-cycle completion of the current request
- flush_cnt  out  16  redirect counter (only with GCORE_PREFETCH_STATS_EN)

Behaviour:
- Interface: one clock domain; reset asynchronous, active-low; reset port is rst, clock port is clk.
- Reset values:
  - inst_valid=0, inst_in=0, mem_rd=0, mem_addr=RESET_ADDR.
  - FIFO empty; head_addr=fetch_addr=RESET_ADDR; state IDLE.
- Entry tags: each FIFO entry holds {word}. The head address is tracked in the register head_addr.
- Valid path (combinational):
  - inst_valid = !empty && inst_addr[31:2]==head_addr[31:2]
  - inst_in = head word, 0 when empty.
- Classification, evaluated each cycle on inst_addr:
  - Match: equal to head_addr. Nothing happens.
  - Sequential: equal to head_addr+4 and FIFO non-empty. Pop head; head_addr += 4.
  - Redirect: anything else, or FIFO empty with inst_addr != fetch_addr. Flush FIFO; head_addr=fetch_addr=inst_addr & ~3.
  - A wait on an empty FIFO with inst_addr==head_addr is a match, not a redirect.
- Issue rule:
  - Issue a request only when count + outstanding < DEPTH. At most one request outstanding.
  - Address arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- FSM:
  - IDLE: if credit and no redirect → mem_rd=1, mem_addr=fetch_addr, go FETCH.
  - FETCH: mem_rd=1.
    - On mem_ready: push mem_data; fetch_addr += 4; go IDLE. A back-to-back request may issue the next cycle.
    - On redirect without mem_ready: go DRAIN.
  - DRAIN: mem_rd=1, address unchanged.
    - On mem_ready: discard the word; go IDLE.
    - Further redirects in DRAIN only update fetch_addr.
- Simultaneous events:
  - Redirect + mem_ready in FETCH: word discarded, no push; go IDLE with the new fetch_addr.
  - Pop + push same cycle: count unchanged.
  - Push when full cannot occur (credit rule); assertion in simulation.
- Throughput: with mem_ready one cycle after request, one word per 2 cycles. Latency from redirect to inst_valid = 2 + memory wait cycles.
- Reset mid-request: mem_rd drops asynchronously; the memory side must tolerate an abandoned request.

Optional Feature:
- GCORE_PREFETCH_STATS_EN defined:
  - flush_cnt increments on every redirect that flushes.
  - Saturates at 16'hFFFF; reset to 0.
- Undefined: flush_cnt port is still present but tied to 0; no counter logic.

Decomposition:
- Package gcore_pkg:
  - INST_W=32, ADDR_W=32, WORD_BYTES=4.
  - Prefetch state enum {PF_IDLE, PF_FETCH, PF_DRAIN}.
- Sub-module gcore_inst_fifo:
  - Synchronous FIFO with DEPTH parameter and push/pop/flush.
  - Outputs count/empty/full.
  - flush has priority over push.

Test Plan:
- Reset: rst=0 then 1, mem_ready 1 cycle after mem_rd, inst_addr=0 → first mem_rd with mem_addr=0; inst_valid=1 with inst_in=word0 by cycle 3; mem_addr 0,4,8… sequential.
- Stall: inst_addr held at 0x10, DEPTH=8 → exactly 8 words fetched (0x10..0x2C), then mem_rd stays 0; stepping inst_addr to 0x14 issues one fetch for 0x30.
- Jump: FIFO holding 0x20..0x3C, inst_addr=0x100 → FIFO flushed, inst_valid=0 that cycle, next mem_addr=0x100, flush_cnt=1 (stats on).
- Jump during outstanding request: mem_rd on 0x40 with mem_ready delayed 5 cycles, inst_addr→0x200 → word for 0x40 discarded, then mem_addr=0x200; inst_in for 0x200 correct.
- Redirect coinciding with mem_ready → returning word not pushed; no stale inst_valid.
- Wrap: inst_addr=0xFFFF_FFF8 → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 in order.
